// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_pkg
// Brief   : Shared types and constants for the branch-resolution stage.
// Revision: 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic            taken;
        logic            mispredict;
        logic            illegal;
        logic [XLEN-1:0] redirect_pc;
    } brc_result_t;

    // Only 010 and 011 are unused in the branch funct3 space.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return f3[2] | ~f3[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_stage_if
// Brief   : Branch-op input, result output and counter bus of the stage.
// Revision: 1.0 - initial release
// ============================================================================
interface branch_resolve_stage_if #(
    parameter int W     = 32,
    parameter int CNT_W = 32
);
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_funct3;
    logic [W-1:0]     i_rs1;
    logic [W-1:0]     i_rs2;
    logic [W-1:0]     i_pc;
    logic [W-1:0]     i_imm;
    logic             i_pred_taken;
    logic             o_valid;
    logic             i_ready;
    logic             o_taken;
    logic             o_mispredict;
    logic [W-1:0]     o_redirect_pc;
    logic             o_illegal;
    logic [CNT_W-1:0] o_cnt_branches;
    logic [CNT_W-1:0] o_cnt_mispred;
    logic             i_cnt_clear;

    modport master (
        output i_flush, i_valid, i_funct3, i_rs1, i_rs2, i_pc, i_imm,
               i_pred_taken, i_ready, i_cnt_clear,
        input  o_ready, o_valid, o_taken, o_mispredict, o_redirect_pc,
               o_illegal, o_cnt_branches, o_cnt_mispred
    );

    modport slave (
        input  i_flush, i_valid, i_funct3, i_rs1, i_rs2, i_pc, i_imm,
               i_pred_taken, i_ready, i_cnt_clear,
        output o_ready, o_valid, o_taken, o_mispredict, o_redirect_pc,
               o_illegal, o_cnt_branches, o_cnt_mispred
    );
endinterface
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
// Module  : branch_cmp
// Brief   : W-bit less-than comparator, signed or unsigned by parameter.
// Revision: 1.0 - initial release
// ============================================================================
module branch_cmp #(
    parameter int W          = 32,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);
    generate
        if (SIGNED_CMP) begin : g_signed
            assign lt = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign lt = a < b;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module  : branch_cond_eval
// Brief   : Combinational RV32I branch-condition decode from rs1/rs2/funct3.
// Revision: 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [2:0]   funct3,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    output logic         taken,
    output logic         illegal
);
    logic w_lt_s;
    logic w_lt_u;
    logic w_eq;

    branch_cmp #(.W(W), .SIGNED_CMP(1'b1)) u_cmp_signed (
        .a  (rs1),
        .b  (rs2),
        .lt (w_lt_s)
    );

    branch_cmp #(.W(W), .SIGNED_CMP(1'b0)) u_cmp_unsigned (
        .a  (rs1),
        .b  (rs2),
        .lt (w_lt_u)
    );

    assign w_eq    = (rs1 == rs2);
    assign illegal = ~f3_is_legal(funct3);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = w_eq;
            F3_BNE:  taken = ~w_eq;
            F3_BLT:  taken = w_lt_s;
            F3_BGE:  taken = ~w_lt_s;
            F3_BLTU: taken = w_lt_u;
            F3_BGEU: taken = ~w_lt_u;
            default: taken = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/branch_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_stage
// Brief   : Registered branch resolution with valid/ready and perf counters.
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_stage
    import branch_pkg::*;
#(
    parameter int W     = XLEN,
    parameter int CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    branch_resolve_stage_if.slave bus
);
    logic             w_taken;
    logic             w_illegal;
    logic             w_accept;
    logic [W-1:0]     w_target;
    logic [W-1:0]     w_fall;
    brc_result_t      w_next;

    logic             r_valid;
    brc_result_t      r_res;
    logic [CNT_W-1:0] r_cnt_br;
    logic [CNT_W-1:0] r_cnt_mp;

    branch_cond_eval #(.W(W)) u_cond (
        .funct3  (bus.i_funct3),
        .rs1     (bus.i_rs1),
        .rs2     (bus.i_rs2),
        .taken   (w_taken),
        .illegal (w_illegal)
    );

    assign w_target = bus.i_pc + bus.i_imm;
    assign w_fall   = bus.i_pc + W'(4);

    always_comb begin
        w_next             = '0;
        w_next.taken       = w_taken;
        w_next.illegal     = w_illegal;
        w_next.mispredict  = ~w_illegal & (w_taken ^ bus.i_pred_taken);
        w_next.redirect_pc = w_taken ? w_target : w_fall;
    end

    assign bus.o_ready = ~r_valid | bus.i_ready;
    assign w_accept    = bus.i_valid & bus.o_ready & ~bus.i_flush;

    // Valid bit is the whole EMPTY/FULL state; flush dominates accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
        end else begin
            if (bus.i_flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (bus.i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_res <= w_next;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt_br <= '0;
            r_cnt_mp <= '0;
        end else if (bus.i_cnt_clear) begin
            r_cnt_br <= '0;
            r_cnt_mp <= '0;
        end else if (w_accept && !w_next.illegal) begin
            r_cnt_br <= r_cnt_br + CNT_W'(1);
            if (w_next.mispredict) begin
                r_cnt_mp <= r_cnt_mp + CNT_W'(1);
            end
        end
    end

    assign bus.o_valid        = r_valid;
    assign bus.o_taken        = r_res.taken;
    assign bus.o_mispredict   = r_res.mispredict;
    assign bus.o_illegal      = r_res.illegal;
    assign bus.o_redirect_pc  = r_res.redirect_pc;
    assign bus.o_cnt_branches = r_cnt_br;
    assign bus.o_cnt_mispred  = r_cnt_mp;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve_stage
// Brief   : Scoreboard bench for branch_resolve_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_resolve_stage;
    import branch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_resolve_stage_if #(.W(32), .CNT_W(32)) bus ();

    branch_resolve_stage #(.W(32), .CNT_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    brc_result_t q[$];
    logic [31:0] m_br = '0;
    logic [31:0] m_mp = '0;

    function automatic brc_result_t model(input logic [2:0] f3, input logic [31:0] rs1,
                                          input logic [31:0] rs2, input logic [31:0] pc,
                                          input logic [31:0] imm, input logic pred);
        brc_result_t r;
        logic t;
        logic ill;
        t   = 1'b0;
        ill = 1'b0;
        case (f3)
            3'b000: t = (rs1 == rs2);
            3'b001: t = (rs1 != rs2);
            3'b100: t = ($signed(rs1) <  $signed(rs2));
            3'b101: t = ($signed(rs1) >= $signed(rs2));
            3'b110: t = (rs1 <  rs2);
            3'b111: t = (rs1 >= rs2);
            default: ill = 1'b1;
        endcase
        r             = '0;
        r.taken       = t;
        r.illegal     = ill;
        r.mispredict  = !ill && (t != pred);
        r.redirect_pc = t ? pc + imm : pc + 32'd4;
        return r;
    endfunction

    // Drives one cycle of stimulus and records the expectation if accepted.
    task automatic issue(input logic v, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input logic flush, input logic clr, input logic rdy);
        brc_result_t e;
        @(posedge clk);
        #2;
        bus.i_valid      = v;
        bus.i_funct3     = f3;
        bus.i_rs1        = rs1;
        bus.i_rs2        = rs2;
        bus.i_pc         = pc;
        bus.i_imm        = imm;
        bus.i_pred_taken = pred;
        bus.i_flush      = flush;
        bus.i_cnt_clear  = clr;
        bus.i_ready      = rdy;
        #1;
        if (v && bus.o_ready && !flush && rst_n) begin
            e = model(f3, rs1, rs2, pc, imm, pred);
            q.push_back(e);
            if (!clr && !e.illegal) begin
                m_br = m_br + 32'd1;
                if (e.mispredict) m_mp = m_mp + 32'd1;
            end
        end
        if (clr) begin
            m_br = '0;
            m_mp = '0;
        end
    endtask

    task automatic idle(input logic rdy);
        issue(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    always @(negedge clk) begin
        brc_result_t e;
        brc_result_t got;
        if (rst_n && bus.o_valid && bus.i_ready) begin
            n_total++;
            got = {bus.o_taken, bus.o_mispredict, bus.o_illegal, bus.o_redirect_pc};
            if (q.size() == 0) begin
                $display("FAIL result: unexpected output %h, scoreboard empty", got);
            end else begin
                e = q.pop_front();
                if (got !== e) $display("FAIL result: got %h expected %h", got, e);
                else n_pass++;
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_cnt_clear = 1'b0; bus.i_ready = 1'b1;
        bus.i_funct3 = '0; bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_pc = '0; bus.i_imm = '0;
        bus.i_pred_taken = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({bus.o_valid, bus.o_taken, bus.o_mispredict, bus.o_illegal} !== 4'b0)
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.o_valid, bus.o_taken, bus.o_mispredict, bus.o_illegal});
        else n_pass++;
        n_total++;
        if (bus.o_redirect_pc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", bus.o_redirect_pc);
        else n_pass++;
        n_total++;
        if ({bus.o_cnt_branches, bus.o_cnt_mispred} !== 64'h0)
            $display("FAIL reset_cnt: got %h/%h expected 0/0", bus.o_cnt_branches, bus.o_cnt_mispred);
        else n_pass++;
        n_total++;
        if (bus.o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.o_ready);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_blt;
        issue(1'b1, F3_BLT, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        n_total++;
        if (bus.o_valid !== 1'b1 || bus.o_redirect_pc !== 32'h120)
            $display("FAIL blt: got valid=%b pc=%h expected valid=1 pc=00000120", bus.o_valid, bus.o_redirect_pc);
        else n_pass++;
        n_total++;
        if (bus.o_cnt_mispred !== 32'd1 || bus.o_cnt_branches !== 32'd1)
            $display("FAIL blt_cnt: got %0d/%0d expected 1/1", bus.o_cnt_branches, bus.o_cnt_mispred);
        else n_pass++;
    endtask

    task automatic test_bltu;
        issue(1'b1, F3_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        n_total++;
        if (bus.o_taken !== 1'b0 || bus.o_mispredict !== 1'b0 || bus.o_redirect_pc !== 32'h104)
            $display("FAIL bltu: got t=%b m=%b pc=%h expected t=0 m=0 pc=00000104",
                     bus.o_taken, bus.o_mispredict, bus.o_redirect_pc);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [8];
        logic [31:0] tb [8];
        ta[0] = 32'h0;         tb[0] = 32'h0;
        ta[1] = 32'h5;         tb[1] = 32'h7;
        ta[2] = 32'h8000_0000; tb[2] = 32'h7FFF_FFFF;
        ta[3] = 32'h7FFF_FFFF; tb[3] = 32'h8000_0000;
        ta[4] = 32'hFFFF_FFFF; tb[4] = 32'h1;
        for (int i = 5; i < 8; i++) begin
            ta[i] = $urandom;
            tb[i] = (i == 5) ? ta[i] : $urandom;
        end
        for (int p = 0; p < 8; p++) begin
            for (int f = 0; f < 8; f++) begin
                issue(1'b1, 3'(f), ta[p], tb[p], $urandom, $urandom, 1'($urandom),
                      1'b0, 1'b0, 1'b1);
            end
        end
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        n_total++;
        if (q.size() != 0) $display("FAIL b2b_drain: got %0d pending expected 0", q.size());
        else n_pass++;
        n_total++;
        if (bus.o_cnt_branches !== m_br || bus.o_cnt_mispred !== m_mp)
            $display("FAIL b2b_cnt: got %0d/%0d expected %0d/%0d",
                     bus.o_cnt_branches, bus.o_cnt_mispred, m_br, m_mp);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        brc_result_t ea;
        ea = model(F3_BNE, 32'h3, 32'h4, 32'h2000, 32'hFFFF_FFF0, 1'b0);
        issue(1'b1, F3_BNE, 32'h3, 32'h4, 32'h2000, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            issue(1'b1, F3_BGE, 32'h9, 32'h2, 32'h3000, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            n_total++;
            if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1 ||
                {bus.o_taken, bus.o_mispredict, bus.o_illegal, bus.o_redirect_pc} !== ea)
                $display("FAIL stall%0d: got rdy=%b v=%b res=%h expected rdy=0 v=1 res=%h", c,
                         bus.o_ready, bus.o_valid,
                         {bus.o_taken, bus.o_mispredict, bus.o_illegal, bus.o_redirect_pc}, ea);
            else n_pass++;
        end
        issue(1'b1, F3_BGE, 32'h9, 32'h2, 32'h3000, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (q.size() != 2) $display("FAIL stall_accept: got %0d queued expected 2", q.size());
        else n_pass++;
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_illegal;
        logic [31:0] br0;
        logic [31:0] mp0;
        br0 = m_br;
        mp0 = m_mp;
        issue(1'b1, 3'b010, 32'h1, 32'h1, 32'h400, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        n_total++;
        if (bus.o_illegal !== 1'b1 || bus.o_taken !== 1'b0 || bus.o_mispredict !== 1'b0 ||
            bus.o_redirect_pc !== 32'h404)
            $display("FAIL illegal: got i=%b t=%b m=%b pc=%h expected i=1 t=0 m=0 pc=00000404",
                     bus.o_illegal, bus.o_taken, bus.o_mispredict, bus.o_redirect_pc);
        else n_pass++;
        n_total++;
        if (bus.o_cnt_branches !== br0 || bus.o_cnt_mispred !== mp0)
            $display("FAIL illegal_cnt: got %0d/%0d expected %0d/%0d",
                     bus.o_cnt_branches, bus.o_cnt_mispred, br0, mp0);
        else n_pass++;
    endtask

    task automatic test_wrap;
        issue(1'b1, F3_BEQ, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        n_total++;
        if (bus.o_redirect_pc !== 32'h4) $display("FAIL wrap: got %h expected 00000004", bus.o_redirect_pc);
        else n_pass++;
    endtask

    task automatic test_flush;
        issue(1'b1, F3_BEQ, 32'h1, 32'h2, 32'h500, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, F3_BLT, 32'hFFFF_FFFF, 32'h1, 32'h600, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        void'(q.pop_back());
        n_total++;
        if (bus.o_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", bus.o_valid);
        else n_pass++;
        n_total++;
        if (bus.o_cnt_branches !== m_br || bus.o_cnt_mispred !== m_mp)
            $display("FAIL flush_cnt: got %0d/%0d expected %0d/%0d",
                     bus.o_cnt_branches, bus.o_cnt_mispred, m_br, m_mp);
        else n_pass++;
    endtask

    task automatic test_cnt_clear;
        issue(1'b1, F3_BNE, 32'h1, 32'h2, 32'h700, 32'h8, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        @(negedge clk);
        n_total++;
        if (bus.o_cnt_branches !== 32'd0 || bus.o_cnt_mispred !== 32'd0)
            $display("FAIL clear: got %0d/%0d expected 0/0", bus.o_cnt_branches, bus.o_cnt_mispred);
        else n_pass++;
        issue(1'b1, F3_BNE, 32'h1, 32'h2, 32'h700, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        n_total++;
        if (bus.o_cnt_branches !== 32'd1 || bus.o_cnt_mispred !== 32'd1)
            $display("FAIL clear_then_count: got %0d/%0d expected 1/1",
                     bus.o_cnt_branches, bus.o_cnt_mispred);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        issue(1'b1, F3_BLT, 32'hFFFF_FFFF, 32'h1, 32'h800, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        m_br = '0;
        m_mp = '0;
        n_total++;
        if ({bus.o_valid, bus.o_taken, bus.o_mispredict, bus.o_illegal, bus.o_redirect_pc,
             bus.o_cnt_branches, bus.o_cnt_mispred} !== 100'h0)
            $display("FAIL reset_mid: got v=%b t=%b m=%b i=%b pc=%h cnt=%0d/%0d expected all 0",
                     bus.o_valid, bus.o_taken, bus.o_mispredict, bus.o_illegal,
                     bus.o_redirect_pc, bus.o_cnt_branches, bus.o_cnt_mispred);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_blt();
        test_bltu();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_flush();
        test_cnt_clear();
        test_reset_mid();
        idle(1'b1);
        @(negedge clk);
        n_total++;
        if (q.size() != 0) $display("FAIL final_drain: got %0d pending expected 0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
